// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clk_div_bank divided-clock generator.
package clk_div_pkg;

  localparam int unsigned ChanW   = 4;
  localparam int unsigned MaxDivW = 16;

  typedef enum logic [1:0] {StAlign, StSettle, StLocked} state_e;

  // Phase offsets beyond the period are clamped to the last count.
  function automatic logic [MaxDivW-1:0] eff_phase(input logic [MaxDivW-1:0] phase,
                                                   input logic [MaxDivW-1:0] div);
    return (phase >= div) ? div - MaxDivW'(1) : phase;
  endfunction

  // ceil(div/2) without needing an extra carry bit.
  function automatic logic [MaxDivW-1:0] high_time(input logic [MaxDivW-1:0] div);
    return (div >> 1) + {{(MaxDivW - 1){1'b0}}, div[0]};
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: shadow/active divisor and phase, wrap counter, registered stb/outclk.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] wr_div_i,
  input  logic [DIV_W-1:0] wr_phase_i,
  input  logic             load_i,
  input  logic             clear_i,
  output logic             stb_o,
  output logic             outclk_o
);

  localparam logic [DIV_W-1:0] DefDiv = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] shadow_div_q, shadow_div_d;
  logic [DIV_W-1:0] shadow_phase_q, shadow_phase_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] phase_q, phase_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] eff_d, high_d, dist_d;
  logic             stb_q, stb_d;
  logic             outclk_q, outclk_d;

  always_comb begin
    shadow_div_d   = shadow_div_q;
    shadow_phase_d = shadow_phase_q;
    if (wr_i) begin
      shadow_div_d   = (wr_div_i == '0) ? DIV_W'(1) : wr_div_i;
      shadow_phase_d = wr_phase_i;
    end

    div_d   = div_q;
    phase_d = phase_q;
    if (load_i) begin
      div_d   = shadow_div_q;
      phase_d = shadow_phase_q;
    end

    if (clear_i || (cnt_q >= div_q - DIV_W'(1))) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    // Outputs are decoded from the next counter value so they line up with it.
    eff_d    = DIV_W'(eff_phase(MaxDivW'(phase_d), MaxDivW'(div_d)));
    high_d   = DIV_W'(high_time(MaxDivW'(div_d)));
    dist_d   = (cnt_d >= eff_d) ? (cnt_d - eff_d) : (cnt_d + (div_d - eff_d));
    stb_d    = (cnt_d == eff_d);
    outclk_d = (dist_d < high_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_div_q   <= DefDiv;
      shadow_phase_q <= '0;
      div_q          <= DefDiv;
      phase_q        <= '0;
      cnt_q          <= '0;
      stb_q          <= 1'b0;
      outclk_q       <= 1'b0;
    end else begin
      shadow_div_q   <= shadow_div_d;
      shadow_phase_q <= shadow_phase_d;
      div_q          <= div_d;
      phase_q        <= phase_d;
      cnt_q          <= cnt_d;
      stb_q          <= stb_d;
      outclk_q       <= outclk_d;
    end
  end

  assign stb_o    = stb_q;
  assign outclk_o = outclk_q;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel divided-clock / strobe generator with realign-and-settle lock FSM.
// Optional CLK_DIV_BANK_GATE_EN masks stb/outclk until locked.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CLKS    = 4,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 5,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                refclk_i,
  input  logic                rst_ni,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [ChanW-1:0]    cfg_chan_i,
  input  logic [DIV_W-1:0]    cfg_div_i,
  input  logic [DIV_W-1:0]    cfg_phase_i,
  output logic                cfg_err_o,
  output logic [NUM_CLKS-1:0] outclk_o,
  output logic [NUM_CLKS-1:0] stb_o,
  output logic                locked_o
);

  localparam int unsigned    SetW     = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SetW-1:0] SetLast = SetW'(LOCK_CYCLES - 1);
  localparam logic [ChanW:0] NumClksW = (ChanW + 1)'(NUM_CLKS);

  state_e            state_q, state_d;
  logic [SetW-1:0]   settle_q, settle_d;
  logic              cfg_err_q;
  logic              accept, chan_ok, cfg_ok;
  logic              load, clear;
  logic [NUM_CLKS-1:0] chan_stb, chan_outclk;

  assign accept = cfg_valid_i & cfg_ready_o;
  assign chan_ok = ({1'b0, cfg_chan_i} < NumClksW);
  assign cfg_ok  = accept & chan_ok;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    load     = 1'b0;
    clear    = 1'b0;
    unique case (state_q)
      StAlign: begin
        load     = 1'b1;
        clear    = 1'b1;
        settle_d = '0;
        state_d  = StSettle;
      end
      StSettle: begin
        if (cfg_ok) begin
          state_d = StAlign;
        end else if (settle_q == SetLast) begin
          state_d = StLocked;
        end else begin
          settle_d = settle_q + SetW'(1);
        end
      end
      StLocked: begin
        if (cfg_ok) state_d = StAlign;
      end
      default: state_d = StAlign;
    endcase
  end

  always_ff @(posedge refclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StAlign;
      settle_q  <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      cfg_err_q <= accept & ~chan_ok;
    end
  end

  assign cfg_ready_o = (state_q != StAlign);
  assign locked_o    = (state_q == StLocked);
  assign cfg_err_o   = cfg_err_q;

  for (genvar i = 0; i < NUM_CLKS; i++) begin : g_chan
    clk_div_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_i      (refclk_i),
      .rst_ni     (rst_ni),
      .wr_i       (cfg_ok && (cfg_chan_i == ChanW'(i))),
      .wr_div_i   (cfg_div_i),
      .wr_phase_i (cfg_phase_i),
      .load_i     (load),
      .clear_i    (clear),
      .stb_o      (chan_stb[i]),
      .outclk_o   (chan_outclk[i])
    );
  end

`ifdef CLK_DIV_BANK_GATE_EN
  assign stb_o    = chan_stb & {NUM_CLKS{locked_o}};
  assign outclk_o = chan_outclk & {NUM_CLKS{locked_o}};
`else
  assign stb_o    = chan_stb;
  assign outclk_o = chan_outclk;
`endif

endmodule
